alu_cmd_sequencer: RTL

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

---
 rtl/alu_cmd_sequencer.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
// Buffers {a, b, op} commands in a small FIFO, issues them one at a time to a
// multi-cycle downstream ALU, and returns each result through a response
// handshake in command order. After every ALU completion a drain counter
// holds off the next issue for DRAIN_CYCLES cycles.
// Optional feature: define ALU_SEQ_TIMEOUT_EN to abort a RUN that lasts
// TIMEOUT cycles without alu_done. The abort returns 16'hFFFF with
// rsp_timeout set.
module alu_cmd_sequencer #(
   parameter int DEPTH        = 4,
   parameter int DRAIN_CYCLES = 4,
   parameter int TIMEOUT      = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd_a,
   input  logic [7:0]  cmd_b,
   input  logic [2:0]  cmd_op,
   output logic        alu_start,
   output logic [7:0]  alu_a,
   output logic [7:0]  alu_b,
   output logic [2:0]  alu_op,
   input  logic        alu_done,
   input  logic [15:0] alu_result,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_result,
   output logic [2:0]  rsp_op,
   output logic        rsp_timeout,
   output logic        busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
   localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES);
   localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   // Elaboration-time parameter sanity checks
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("alu_cmd_sequencer: DEPTH must be a power of two >= 2");
   end
   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("alu_cmd_sequencer: TIMEOUT must be >= 1");
   end

   logic [18:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_cmd_ready;
   logic [1:0]    r_state;
   logic [7:0]    r_alu_a;
   logic [7:0]    r_alu_b;
   logic [2:0]    r_alu_op;
   logic [15:0]   r_rsp_result;
   logic [2:0]    r_rsp_op;
   logic [DW-1:0] r_drain;

   logic          w_push;
   logic          w_pop;
   logic          w_empty;
   logic [18:0]   w_head;
   logic [CW-1:0] w_count_nxt;
   logic          w_drain_load;

   assign w_empty = (r_count == '0);
   assign w_push  = cmd_valid & r_cmd_ready;
   // Issue only from IDLE, with something queued, once the drain window has closed
   assign w_pop   = (r_state == S_IDLE) & ~w_empty & (r_drain == '0);
   assign w_head  = r_mem[r_rd_ptr];

`ifdef ALU_SEQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

   logic [TW-1:0] r_to_cnt;
   logic          r_rsp_timeout;
   logic          w_timeout_hit;

   // Abort fires on the TIMEOUT-th consecutive RUN cycle without a completion
   assign w_timeout_hit = (r_state == S_RUN) & ~alu_done & (r_to_cnt == TO_LAST);
   assign w_drain_load  = (r_state == S_RUN) & (alu_done | w_timeout_hit);
   assign rsp_timeout   = r_rsp_timeout;

   // Count consecutive RUN cycles of the current command
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_to_cnt <= '0;
      end else if (w_pop) begin
         r_to_cnt <= '0;
      end else if (r_state == S_RUN && !alu_done && !w_timeout_hit) begin
         r_to_cnt <= r_to_cnt + TW'(1);
      end
   end
`else
   assign w_drain_load = (r_state == S_RUN) & alu_done;
   assign rsp_timeout  = 1'b0;
`endif

   // Next FIFO occupancy, used to register cmd_ready a cycle ahead
   always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_pop) begin
         w_count_nxt = r_count + CW'(1);
      end else if (!w_push && w_pop) begin
         w_count_nxt = r_count - CW'(1);
      end
   end

   // FIFO storage; contents need no reset because the pointers define validity
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {cmd_a, cmd_b, cmd_op};
      end
   end

   // FIFO pointers, occupancy and registered ready
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_cmd_ready <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_count     <= w_count_nxt;
         r_cmd_ready <= (w_count_nxt != FULL_CNT);
      end
   end

   // Drain counter: loaded on completion, otherwise counts down to zero in any state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_drain <= '0;
      end else if (w_drain_load) begin
         r_drain <= DRAIN_LOAD;
      end else if (r_drain != '0) begin
         r_drain <= r_drain - DW'(1);
      end
   end

   // Sequencer FSM with the ALU operand and response payload registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_alu_a      <= '0;
         r_alu_b      <= '0;
         r_alu_op     <= '0;
         r_rsp_result <= '0;
         r_rsp_op     <= '0;
`ifdef ALU_SEQ_TIMEOUT_EN
         r_rsp_timeout <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_alu_a  <= w_head[18:11];
                  r_alu_b  <= w_head[10:3];
                  r_alu_op <= w_head[2:0];
                  if (w_head[2:0] != 3'b000) begin
                     r_state <= S_RUN;
                  end else begin
                     // NOP bypasses the ALU and answers with zero
                     r_rsp_result <= '0;
                     r_rsp_op     <= 3'b000;
`ifdef ALU_SEQ_TIMEOUT_EN
                     r_rsp_timeout <= 1'b0;
`endif
                     r_state      <= S_RESP;
                  end
               end
            end
            S_RUN: begin
               if (alu_done) begin
                  r_rsp_result <= alu_result;
                  r_rsp_op     <= r_alu_op;
`ifdef ALU_SEQ_TIMEOUT_EN
                  r_rsp_timeout <= 1'b0;
`endif
                  r_state      <= S_RESP;
               end
`ifdef ALU_SEQ_TIMEOUT_EN
               else if (w_timeout_hit) begin
                  r_rsp_result  <= 16'hFFFF;
                  r_rsp_op      <= r_alu_op;
                  r_rsp_timeout <= 1'b1;
                  r_state       <= S_RESP;
               end
`endif
            end
            S_RESP: begin
               if (rsp_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign cmd_ready  = r_cmd_ready;
   assign alu_start  = (r_state == S_RUN);
   assign alu_a      = r_alu_a;
   assign alu_b      = r_alu_b;
   assign alu_op     = r_alu_op;
   assign rsp_valid  = (r_state == S_RESP);
   assign rsp_result = r_rsp_result;
   assign rsp_op     = r_rsp_op;
   assign busy       = ~w_empty | (r_state != S_IDLE) | (r_drain != '0);

endmodule
